// File: rtl/snake_move_ctrl.sv
// Snake head movement sequencer for the 8x8 LED row-register array.
// Ports: clk, reset (async, active-high), start, dir_valid, dir[1:0] in;
//   row_sel, src_row_sel, col_mask, shift_left, shift_right, load,
//   step_done, head_row, head_col, game_over, busy out (all registered).
// Optional feature: define SNAKE_WRAP_EN to wrap moves at the walls
//   instead of ending the game.
module snake_move_ctrl #(
    parameter int unsigned TICK_DIV  = 8,
    parameter logic [2:0]  START_ROW = 3'd3,
    parameter logic [2:0]  START_COL = 3'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    output logic [7:0] row_sel,
    output logic [7:0] src_row_sel,
    output logic [7:0] col_mask,
    output logic       shift_left,
    output logic       shift_right,
    output logic       load,
    output logic       step_done,
    output logic [2:0] head_row,
    output logic [2:0] head_col,
    output logic       game_over,
    output logic       busy
);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MOVE,
        S_OVER
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    cur_dir;
    logic [1:0]    cur_nxt;
    logic [1:0]    pend_dir;
    logic [1:0]    pend_nxt;

    logic [2:0] new_row;
    logic [2:0] new_col;
    logic       wall;
    logic       vert;

    logic [7:0] row_sel_d;
    logic [7:0] src_d;
    logic [7:0] mask_d;
    logic       sl_d;
    logic       sr_d;
    logic       ld_d;
    logic       sd_d;
    logic       go_d;
    logic       busy_d;
    logic [2:0] head_row_d;
    logic [2:0] head_col_d;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'd1 << idx;
    endfunction

    // Candidate head position for the pending direction and wall test.
    always_comb begin
        new_row = head_row;
        new_col = head_col;
        wall    = 1'b0;
        vert    = 1'b0;
        unique case (pend_dir)
            D_UP: begin
                new_row = head_row - 3'd1;
                wall    = (head_row == 3'd0);
                vert    = 1'b1;
            end
            D_DOWN: begin
                new_row = head_row + 3'd1;
                wall    = (head_row == 3'd7);
                vert    = 1'b1;
            end
            D_LEFT: begin
                new_col = head_col + 3'd1;
                wall    = (head_col == 3'd7);
            end
            D_RIGHT: begin
                new_col = head_col - 3'd1;
                wall    = (head_col == 3'd0);
            end
        endcase
        if (WRAP) begin
            wall = 1'b0;
        end
    end

    // State register with tick counter and direction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_dir  <= D_RIGHT;
            pend_dir <= D_RIGHT;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_dir  <= cur_nxt;
            pend_dir <= pend_nxt;
        end
    end

    // Next-state logic. Reversals are judged against the committed
    // direction, so a request during MOVE sees the old cur_dir.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        cur_nxt   = cur_dir;
        pend_nxt  = pend_dir;

        if (dir_valid && (state != S_OVER)
            && (dir != (cur_dir ^ 2'b01))) begin
            pend_nxt = dir;
        end

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_MOVE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_MOVE: begin
                cur_nxt = pend_dir;
                if (wall) begin
                    state_nxt = S_OVER;
                end else if (start) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_OVER: begin
                state_nxt = S_OVER;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        row_sel_d  = 8'd0;
        src_d      = 8'd0;
        mask_d     = 8'd0;
        sl_d       = 1'b0;
        sr_d       = 1'b0;
        ld_d       = 1'b0;
        sd_d       = 1'b0;
        go_d       = game_over;
        head_row_d = head_row;
        head_col_d = head_col;
        busy_d     = (state_nxt == S_RUN) || (state_nxt == S_MOVE);

        if (state == S_MOVE) begin
            if (wall) begin
                go_d = 1'b1;
            end else begin
                sd_d       = 1'b1;
                head_row_d = new_row;
                head_col_d = new_col;
                if (vert) begin
                    row_sel_d = onehot(new_row);
                    src_d     = onehot(head_row);
                    mask_d    = onehot(head_col);
                    ld_d      = 1'b1;
                end else begin
                    row_sel_d = onehot(head_row);
                    sl_d      = (pend_dir == D_LEFT);
                    sr_d      = (pend_dir == D_RIGHT);
                end
            end
        end
    end

    // Output registers; reset clears any strobe in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_sel     <= 8'd0;
            src_row_sel <= 8'd0;
            col_mask    <= 8'd0;
            shift_left  <= 1'b0;
            shift_right <= 1'b0;
            load        <= 1'b0;
            step_done   <= 1'b0;
            game_over   <= 1'b0;
            busy        <= 1'b0;
            head_row    <= START_ROW;
            head_col    <= START_COL;
        end else begin
            row_sel     <= row_sel_d;
            src_row_sel <= src_d;
            col_mask    <= mask_d;
            shift_left  <= sl_d;
            shift_right <= sr_d;
            load        <= ld_d;
            step_done   <= sd_d;
            game_over   <= go_d;
            busy        <= busy_d;
            head_row    <= head_row_d;
            head_col    <= head_col_d;
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Testbench for snake_move_ctrl: directed moves, direction filtering,
// wall handling, start release and reset behaviour.
module tb_snake_move_ctrl;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir_valid;
    logic [1:0] dir;
    logic [7:0] row_sel;
    logic [7:0] src_row_sel;
    logic [7:0] col_mask;
    logic       shift_left;
    logic       shift_right;
    logic       load;
    logic       step_done;
    logic [2:0] head_row;
    logic [2:0] head_col;
    logic       game_over;
    logic       busy;

    snake_move_ctrl #(
        .TICK_DIV (TD),
        .START_ROW(3'd3),
        .START_COL(3'd3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir_valid  (dir_valid),
        .dir        (dir),
        .row_sel    (row_sel),
        .src_row_sel(src_row_sel),
        .col_mask   (col_mask),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .load       (load),
        .step_done  (step_done),
        .head_row   (head_row),
        .head_col   (head_col),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [34:0] v;
    } exp_t;

    exp_t q[$];

    task automatic push(input int c,
                        input logic [7:0] rs, input logic [7:0] srs,
                        input logic [7:0] cm,
                        input logic sl, input logic sr, input logic ld,
                        input logic sd, input logic go,
                        input logic [2:0] hr, input logic [2:0] hc);
        exp_t e;
        e.cyc = c;
        e.v   = {rs, srs, cm, sl, sr, ld, sd, go, hr, hc};
        q.push_back(e);
    endtask

    // Monitor: any command or a new game_over consumes one expectation.
    exp_t        me;
    logic [34:0] mact;
    logic        go_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset && (step_done || shift_left || shift_right || load
                       || (game_over && !go_prev))) begin
            mact = {row_sel, src_row_sel, col_mask, shift_left,
                    shift_right, load, step_done, game_over,
                    head_row, head_col};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_cmd cyc=%0d got=%h", cyc, mact);
            end else begin
                me = q.pop_front();
                if (mact !== me.v || cyc != me.cyc) begin
                    bad++;
                    $display("FAIL step cyc=%0d got=%h want cyc=%0d %h",
                             cyc, mact, me.cyc, me.v);
                end
            end
        end
        go_prev = game_over;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk_clear(input string name, input logic [2:0] r,
                             input logic [2:0] c);
        chk({name, "_cmd"},
            {3'd0, row_sel, src_row_sel, col_mask, shift_left,
             shift_right, load, step_done}, 32'd0);
        chk({name, "_head"}, {26'd0, head_row, head_col}, {26'd0, r, c});
        chk({name, "_flags"}, {30'd0, game_over, busy}, 32'd0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_dir(input int c, input logic [1:0] d);
        wait_cyc(c);
        dir_valid = 1'b1;
        dir       = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    // Assert reset between edges, check everything cleared, release.
    task automatic hit_reset(input string name);
        #1;
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk_clear(name, 3'd3, 3'd3);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int k;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        dir_valid = 1'b0;
        dir       = 2'b00;
        @(negedge clk);
        chk_clear("por", 3'd3, 3'd3);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_clear("idle", 3'd3, 3'd3);

        // Segment A: right, right, up x3, left, then up into row 0.
        k = cyc;
        start = 1'b1;
        push(k+6,  8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd2);
        push(k+11, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd1);
        push(k+16, 8'h04, 8'h08, 8'h02, 0, 0, 1, 1, 0, 3'd2, 3'd1);
        push(k+21, 8'h02, 8'h04, 8'h02, 0, 0, 1, 1, 0, 3'd1, 3'd1);
        push(k+26, 8'h01, 8'h02, 8'h02, 0, 0, 1, 1, 0, 3'd0, 3'd1);
        push(k+31, 8'h01, 8'h00, 8'h00, 1, 0, 0, 1, 0, 3'd0, 3'd2);
`ifdef SNAKE_WRAP_EN
        push(k+36, 8'h80, 8'h01, 8'h04, 0, 0, 1, 1, 0, 3'd7, 3'd2);
        push(k+41, 8'h40, 8'h80, 8'h04, 0, 0, 1, 1, 0, 3'd6, 3'd2);
        push(k+46, 8'h20, 8'h40, 8'h04, 0, 0, 1, 1, 0, 3'd5, 3'd2);
`else
        push(k+36, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 3'd0, 3'd2);
`endif
        wait_cyc(k+3);
        chk("busy_run", {31'd0, busy}, 32'd1);
        pulse_dir(k+7,  2'b10);
        pulse_dir(k+12, 2'b00);
        pulse_dir(k+20, 2'b01);
        pulse_dir(k+25, 2'b10);
        pulse_dir(k+33, 2'b00);
        pulse_dir(k+38, 2'b01);
        wait_cyc(k+48);
`ifndef SNAKE_WRAP_EN
        chk("over_head", {26'd0, head_row, head_col}, {26'd0, 3'd0, 3'd2});
        chk("over_flags", {30'd0, game_over, busy}, 32'd2);
`endif
        hit_reset("rst_a");

        // Segment B: run right into column 0.
        @(negedge clk);
        k = cyc;
        start = 1'b1;
        push(k+6,  8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd2);
        push(k+11, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd1);
        push(k+16, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd0);
`ifdef SNAKE_WRAP_EN
        push(k+21, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd7);
        push(k+26, 8'h04, 8'h08, 8'h80, 0, 0, 1, 1, 0, 3'd2, 3'd7);
`else
        push(k+21, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 3'd3, 3'd0);
`endif
        pulse_dir(k+23, 2'b00);
        wait_cyc(k+28);
`ifndef SNAKE_WRAP_EN
        chk("wall_head", {26'd0, head_row, head_col}, {26'd0, 3'd3, 3'd0});
        chk("wall_flags", {30'd0, game_over, busy}, 32'd2);
`endif
        hit_reset("rst_b");

        // Reset landing on a strobe cycle.
        @(negedge clk);
        k = cyc;
        start = 1'b1;
        push(k+6, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd2);
        wait_cyc(k+6);
        hit_reset("rst_strobe");

        // Reset in the middle of RUN.
        @(negedge clk);
        k = cyc;
        start = 1'b1;
        wait_cyc(k+3);
        hit_reset("rst_run");

        // start dropped mid-tick: one step, then back to IDLE.
        @(negedge clk);
        k = cyc;
        start = 1'b1;
        push(k+6, 8'h08, 8'h00, 8'h00, 0, 1, 0, 1, 0, 3'd3, 3'd2);
        wait_cyc(k+3);
        start = 1'b0;
        wait_cyc(k+8);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        wait_cyc(k+20);
        chk("stop_head", {26'd0, head_row, head_col}, {26'd0, 3'd3, 3'd2});

        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
